// File: rtl/bht_predictor.sv
// Branch history table of saturating counters with optional gshare indexing.
// The lookup is registered (latency 1) and the resolve stage trains the table through the update port.
module bht_predictor #(
  parameter int PC_W   = 32,
  parameter int IDX_W  = 4,
  parameter int CTR_W  = 2,
  parameter int GSHARE = 0,
  parameter int HIST_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              lookup_valid,
  input  logic [PC_W-1:0]   lookup_pc,
  output logic              predict_valid,
  output logic              predict,
  output logic [CTR_W-1:0]  predict_ctr,
  input  logic              update_valid,
  input  logic [PC_W-1:0]   update_pc,
  input  logic              update_taken,
  input  logic              clear
);

  localparam int              ENTRIES  = 1 << IDX_W;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(1) << (CTR_W - 1);
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;
  localparam logic [CTR_W-1:0] CTR_MIN  = '0;

  // Handshake: valid-only, no ready. Every lookup_valid/update_valid/clear
  // pulse is accepted on the edge it is sampled; predict_valid is lookup_valid
  // delayed exactly one cycle and carries no back-pressure.

  logic [CTR_W-1:0]  r_ctr [ENTRIES];
  logic [HIST_W-1:0] r_hist;
  logic              r_pred_valid;
  logic              r_pred;
  logic [CTR_W-1:0]  r_pred_ctr;

  logic [IDX_W-1:0]  w_hist_idx;
  logic [IDX_W-1:0]  w_lk_idx;
  logic [IDX_W-1:0]  w_up_idx;
  logic [CTR_W-1:0]  w_lk_ctr;
  logic [CTR_W-1:0]  w_up_ctr;
  logic [CTR_W-1:0]  w_up_ctr_next;
  logic [HIST_W-1:0] w_hist_next;
  logic              w_unused_bits;

  generate
    if (GSHARE != 0) begin : g_gshare
      assign w_hist_idx  = IDX_W'(r_hist);
      // Truncating {hist, taken} to HIST_W keeps the newest bits, LSB newest.
      assign w_hist_next = HIST_W'({r_hist, update_taken});
    end else begin : g_bimodal
      assign w_hist_idx  = '0;
      assign w_hist_next = '0;
    end
  endgenerate

  assign w_lk_idx = lookup_pc[IDX_W+1:2] ^ w_hist_idx;
  assign w_up_idx = update_pc[IDX_W+1:2] ^ w_hist_idx;
  assign w_lk_ctr = r_ctr[w_lk_idx];
  assign w_up_ctr = r_ctr[w_up_idx];

  // Alignment bits and the PC bits above the index never select an entry.
  assign w_unused_bits = ^{lookup_pc, update_pc, r_hist};

  always_comb begin
    w_up_ctr_next = w_up_ctr;
    if (update_taken) begin
      if (w_up_ctr != CTR_MAX) w_up_ctr_next = w_up_ctr + 1'b1;
    end else begin
      if (w_up_ctr != CTR_MIN) w_up_ctr_next = w_up_ctr - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ENTRIES; i++) r_ctr[i] <= CTR_INIT;
      r_hist <= '0;
    end else if (clear) begin
      for (int i = 0; i < ENTRIES; i++) r_ctr[i] <= CTR_INIT;
      r_hist <= '0;
    end else if (update_valid) begin
      r_ctr[w_up_idx] <= w_up_ctr_next;
      r_hist          <= w_hist_next;
    end
  end

  // Prediction registers read the pre-edge table, so clear/update never bypass.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pred_valid <= 1'b0;
      r_pred       <= 1'b0;
      r_pred_ctr   <= '0;
    end else begin
      r_pred_valid <= lookup_valid;
      if (lookup_valid) begin
        r_pred     <= w_lk_ctr[CTR_W-1];
        r_pred_ctr <= w_lk_ctr;
      end
    end
  end

  assign predict_valid = r_pred_valid;
  assign predict       = r_pred;
  assign predict_ctr   = r_pred_ctr;

endmodule

// File: doc/bht_predictor.md
Name: bht_predictor

Overview:
- Parametrised branch history table: an array of 2^IDX_W saturating counters of CTR_W bits, indexed from the branch PC.
- Optional gshare mode XORs a global history register into the index.
- Sits in the fetch stage: registered lookup port gives the prediction one cycle later; the resolve stage trains the table through the update port.
- Adds a synchronous table clear.

Parameters:
- PC_W, 32, branch PC width.
- IDX_W, 4, table index width (2^IDX_W entries). Legal range 1..PC_W-2.
- CTR_W, 2, counter width (≥1).
- GSHARE, 0, 1 = index is pc[IDX_W+1:2] XOR history; 0 = index is pc[IDX_W+1:2].
- HIST_W, 4, global history length. Legal range 1..IDX_W. Used only when GSHARE=1.

Ports:
- clk, in, 1, rising-edge clock.
- reset_n, in, 1, asynchronous active-low reset.
- lookup_valid, in, 1, lookup request this cycle.
- lookup_pc, in, PC_W, PC of the branch to predict.
- predict_valid, out, 1, prediction valid (lookup_valid delayed one cycle).
- predict, out, 1, 1 = taken (counter MSB).
- predict_ctr, out, CTR_W, counter value read.
- update_valid, in, 1, train request.
- update_pc, in, PC_W, PC of the resolved branch.
- update_taken, in, 1, resolved direction.
- clear, in, 1, synchronous table/history clear.

Behaviour:
- Reset (async assert, any time, including mid-operation):
  - every counter = INIT (MSB=1, other bits 0; 2'b10 for CTR_W=2, weakly taken);
  - history = 0;
  - predict_valid = 0, predict = 0, predict_ctr = 0.
- Index: idx = pc[IDX_W+1:2], XOR {zero-extend(hist)} when GSHARE=1. pc[1:0] are ignored. Aliasing PCs share an entry by design.
- Lookup:
  - lookup_valid at edge N: predict_valid=1, predict=ctr[idx][CTR_W-1] and predict_ctr=ctr[idx] during cycle N+1. Latency 1.
  - No lookup_valid: predict_valid=0 next cycle; predict/predict_ctr hold their last values.
  - Lookup reads table and history as they are before any same-edge update or clear. No bypass.
- Update (update_valid, no clear):
  - Uses the history value before this edge's shift.
  - Taken: ctr = min(ctr+1, 2^CTR_W-1). Not-taken: ctr = max(ctr-1, 0). Saturation, never wrap.
  - Then, when GSHARE=1: hist = {hist[HIST_W-2:0], update_taken}, LSB newest. For HIST_W=1, hist = update_taken.
  - When GSHARE=0, history is unused and held at 0.
- Clear:
  - At the edge, all counters = INIT and history = 0.
  - Clear has priority over a same-cycle update; that update is dropped.
  - A same-cycle lookup still returns the pre-clear value.
- Simultaneous lookup and update to the same idx: lookup returns the old value; the next lookup sees the new value.
- One update per cycle; no back-pressure, all ports always accepted.

Test Plan:
(defaults unless stated; pc 0x40 and 0x80 both map to idx 0, pc 0x44 to idx 1)
1. Reset, then lookup 0x40 → next cycle predict_valid=1, predict=1, predict_ctr=2'b10. The cycle after with no lookup → predict_valid=0.
2. Three not-taken updates to 0x40 → ctr 01, 00, 00 (saturated). Lookup → predict=0, ctr=00. Then three taken updates to 0x44 → idx1 ctr 11, 11, 11; lookup 0x44 → ctr=11.
3. Aliasing: not-taken update to 0x80, then lookup 0x40 → predict_ctr=01, predict=0.
4. Same cycle: lookup 0x40 with taken update 0x40 from ctr 00 → predict_ctr=00. Next lookup → 01.
5. Clear asserted with a taken update to 0x44 (ctr 11) → update dropped; lookup 0x44 → 10. Then assert reset_n=0 mid-stream between clock edges → predict_valid drops to 0 immediately; all entries return to 10.
6. GSHARE=1, HIST_W=4: updates to pc 0x40 of T, T, N.
   - Update indices are 0, 1, 3; entry0 = 11, entry1 = 11, entry3 = 01.
   - hist = 4'b0110.
   - Lookup pc 0x58 (pc idx 6 XOR 6 = 0) → predict=1, ctr=11.
